// File: rtl/spi_controller.sv
// SPI mode-0 controller: one 16-bit {rw, addr[6:0], data[7:0]} frame per accepted request, CIPO captured into rdata.
// Accept to nCS low is 1 clk; req_ready is low for the whole frame and gap, so requests stall until IDLE.
module spi_controller #(
   parameter int CLK_DIV  = 2,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       done,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       sclk,
   output logic       ncs,
   output logic       copi,
   input  logic       cipo
);

   localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_P + 1);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t DIV_LAST   = cnt_t'(CLK_DIV - 1);
   localparam cnt_t SETUP_LAST = cnt_t'(CS_SETUP - 1);
   localparam cnt_t HOLD_LAST  = cnt_t'(CS_HOLD - 1);
   localparam cnt_t IDLE_LAST  = cnt_t'(CS_IDLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t      state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic [3:0]  bit_q, bit_d;
   logic        sclk_q, sclk_d;
   logic [15:0] frame_q, frame_d;
   logic [7:0]  cap_q, cap_d;
   logic        done_q, done_d;
   logic [7:0]  rdata_q, rdata_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         frame_q <= '0;
         cap_q   <= '0;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         frame_q <= frame_d;
         cap_q   <= cap_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      frame_d = frame_q;
      cap_d   = cap_q;
      done_d  = 1'b0;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_SETUP;
               frame_d = {req_write, req_addr, req_wdata};
               cnt_d   = '0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         ST_SHIFT: begin
            // Rising edge samples CIPO; falling edge advances COPI, except after the last bit.
            if (cnt_q == DIV_LAST) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  cap_d = {cap_q[6:0], cipo};
               end else if (bit_q == 4'd15) begin
                  state_d = ST_HOLD;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  frame_d = {frame_q[14:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_GAP;
               cnt_d   = '0;
               done_d  = 1'b1;
               rdata_d = cap_q;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == IDLE_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = ~req_ready;
   assign ncs       = (state_q == ST_IDLE) || (state_q == ST_GAP);
   assign sclk      = sclk_q;
   assign copi      = ((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD)) ? frame_q[15] : 1'b0;
   assign done      = done_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: default-timing and minimum-timing instances checked every cycle against a frame-timing model.
module tb_spi_controller;

   localparam int P_CD [2] = '{2, 1};
   localparam int P_S  [2] = '{2, 1};
   localparam int P_H  [2] = '{2, 1};
   localparam int P_I  [2] = '{2, 1};

   logic       clk;
   logic       rst;
   logic       req_valid [2];
   logic       req_ready [2];
   logic       req_write [2];
   logic [6:0] req_addr  [2];
   logic [7:0] req_wdata [2];
   logic       done      [2];
   logic [7:0] rdata     [2];
   logic       busy      [2];
   logic       sclk      [2];
   logic       ncs       [2];
   logic       copi      [2];
   logic       cipo      [2];

   spi_controller #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .done(done[0]), .rdata(rdata[0]), .busy(busy[0]), .sclk(sclk[0]), .ncs(ncs[0]),
      .copi(copi[0]), .cipo(cipo[0])
   );

   spi_controller #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .done(done[1]), .rdata(rdata[1]), .busy(busy[1]), .sclk(sclk[1]), .ncs(ncs[1]),
      .copi(copi[1]), .cipo(cipo[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Model: cycles since accept, the accepted frame, and the CIPO word the bench plays back.
   bit          m_act [2];
   int          m_t   [2];
   logic [15:0] m_frm [2];
   logic [15:0] m_cw  [2];
   logic [7:0]  m_rd  [2];
   logic [15:0] cw_next [2];
   int          acc_n [2];
   int          acc_cyc [2];
   int          acc_gap [2];

   logic [15:0] dec [2];
   int          rises [2], lowc [2], donec [2], hi_run [2], last_hi [2];
   int          last_rise [2], rise_gap [2];
   logic        p_sclk [2], p_ncs [2], p_copi [2];

   task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", nm, g, a, e, cyc);
      end
   endtask

   task automatic timeout(input string nm, input int g);
      n_cmp++;
      n_bad++;
      $display("FAIL timeout %s dut%0d: wait expired at cycle %0d, expected completion", nm, g, cyc);
   endtask

   task automatic step();
      int L, u, b;
      logic e_ncs, e_sclk, e_copi, e_rdy, e_done;
      logic [7:0] e_rd;
      @(posedge clk);
      cyc++;
      for (int g = 0; g < 2; g++) begin
         L = P_S[g] + 32 * P_CD[g] + P_H[g];
         if (rst) begin
            m_act[g] = 1'b0;
            m_rd[g]  = 8'h00;
         end else if (m_act[g]) begin
            m_t[g] = m_t[g] + 1;
            if (m_t[g] == L + 1) m_rd[g] = m_cw[g][7:0];
            if (m_t[g] > L + P_I[g]) m_act[g] = 1'b0;
         end else if (req_valid[g]) begin
            m_act[g] = 1'b1;
            m_t[g]   = 1;
            m_frm[g] = {req_write[g], req_addr[g], req_wdata[g]};
            m_cw[g]  = cw_next[g];
            if (acc_n[g] > 0) acc_gap[g] = cyc - acc_cyc[g];
            acc_cyc[g] = cyc;
            acc_n[g]++;
         end
      end
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         L = P_S[g] + 32 * P_CD[g] + P_H[g];
         e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0; e_rdy = 1'b1; e_done = 1'b0;
         e_rd  = rst ? 8'h00 : m_rd[g];
         if (!rst && m_act[g]) begin
            e_rdy = 1'b0;
            if (m_t[g] <= P_S[g]) begin
               e_ncs  = 1'b0;
               e_copi = m_frm[g][15];
            end else if (m_t[g] <= P_S[g] + 32 * P_CD[g]) begin
               u      = m_t[g] - P_S[g] - 1;
               b      = u / (2 * P_CD[g]);
               e_ncs  = 1'b0;
               e_sclk = (u % (2 * P_CD[g])) >= P_CD[g];
               e_copi = m_frm[g][15 - b];
            end else if (m_t[g] <= L) begin
               e_ncs  = 1'b0;
               e_copi = m_frm[g][0];
            end else begin
               e_done = (m_t[g] == L + 1);
            end
         end
         chk("ncs", g, ncs[g], e_ncs);
         chk("sclk", g, sclk[g], e_sclk);
         chk("copi", g, copi[g], e_copi);
         chk("req_ready", g, req_ready[g], e_rdy);
         chk("busy", g, busy[g], !e_rdy);
         chk("done", g, done[g], e_done);
         chk("rdata", g, rdata[g], e_rd);

         if (copi[g] !== p_copi[g]) chk("copi_change_sclk_low", g, sclk[g], 1'b0);
         if (!rst && sclk[g] !== p_sclk[g]) chk("sclk_toggle_ncs_low", g, ncs[g], 1'b0);
         if (ncs[g] === 1'b0) lowc[g]++;
         if (done[g] === 1'b1) donec[g]++;
         if (p_sclk[g] === 1'b0 && sclk[g] === 1'b1) begin
            rises[g]++;
            dec[g] = {dec[g][14:0], copi[g]};
            rise_gap[g]  = cyc - last_rise[g];
            last_rise[g] = cyc;
         end
         if (ncs[g] === 1'b1) hi_run[g]++;
         else begin
            if (p_ncs[g] === 1'b1) last_hi[g] = hi_run[g];
            hi_run[g] = 0;
         end
         p_sclk[g] = sclk[g];
         p_ncs[g]  = ncs[g];
         p_copi[g] = copi[g];

         // Peripheral side: present the next CIPO bit during the low phase that precedes its rise.
         if (m_act[g] && m_t[g] <= P_S[g] + 32 * P_CD[g]) begin
            b = (m_t[g] <= P_S[g]) ? 0 : (m_t[g] - P_S[g] - 1) / (2 * P_CD[g]);
            cipo[g] = m_cw[g][15 - b];
         end else begin
            cipo[g] = 1'b0;
         end
      end
   endtask

   task automatic send(input int g, input logic w, input logic [6:0] a, input logic [7:0] d, input logic [15:0] c);
      int n0;
      n0 = acc_n[g];
      req_write[g] = w;
      req_addr[g]  = a;
      req_wdata[g] = d;
      cw_next[g]   = c;
      req_valid[g] = 1'b1;
      for (int k = 0; k < 500 && acc_n[g] == n0; k++) step();
      if (acc_n[g] == n0) timeout("accept", g);
      req_valid[g] = 1'b0;
   endtask

   task automatic wait_idle(input int g);
      for (int k = 0; k < 1000 && m_act[g]; k++) step();
      if (m_act[g]) timeout("idle", g);
   endtask

   initial begin
      int r0, l0, d0, rst_cnt;
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0; req_write[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
         cipo[g] = 1'b0; cw_next[g] = '0; m_act[g] = 1'b0; m_t[g] = 0; m_frm[g] = '0;
         m_cw[g] = '0; m_rd[g] = '0; acc_n[g] = 0; acc_cyc[g] = 0; acc_gap[g] = 0;
         dec[g] = '0; rises[g] = 0; lowc[g] = 0; donec[g] = 0; hi_run[g] = 0; last_hi[g] = 0;
         last_rise[g] = 0; rise_gap[g] = 0; p_sclk[g] = 1'b0; p_ncs[g] = 1'b1; p_copi[g] = 1'b0;
      end
      #1;
      chk("reset_ready", 0, req_ready[0], 1'b1);
      chk("reset_busy", 0, busy[0], 1'b0);
      chk("reset_ncs", 0, ncs[0], 1'b1);
      chk("reset_sclk", 0, sclk[0], 1'b0);
      chk("reset_rdata", 0, rdata[0], 8'h00);
      repeat (3) step();
      rst = 1'b0;
      step();

      // Write 0x00 <- 0xFF at default timing.
      r0 = rises[0]; l0 = lowc[0]; d0 = donec[0];
      send(0, 1'b1, 7'h00, 8'hFF, 16'h1234);
      wait_idle(0);
      chk("wr_frame", 0, dec[0], 16'h80FF);
      chk("wr_rises", 0, rises[0] - r0, 16);
      chk("wr_ncs_low", 0, lowc[0] - l0, 68);
      chk("wr_done_cnt", 0, donec[0] - d0, 1);
      chk("wr_rise_period", 0, rise_gap[0], 4);
      chk("wr_rdata", 0, rdata[0], 8'h34);

      // Read 0x04 with the peripheral returning 0xA5.
      send(0, 1'b0, 7'h04, 8'h5C, 16'h3CA5);
      wait_idle(0);
      chk("rd_frame", 0, dec[0], 16'h045C);
      chk("rd_rdata", 0, rdata[0], 8'hA5);

      // Two back-to-back requests with req_valid held.
      send(0, 1'b1, 7'h01, 8'h12, 16'hBEEF);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 7'h02; req_wdata[0] = 8'h34;
      cw_next[0] = 16'h0F0F;
      for (int k = 0; k < 200 && acc_n[0] < 5; k++) step();
      req_valid[0] = 1'b0;
      wait_idle(0);
      chk("q_acc_spacing", 0, acc_gap[0], 71);
      chk("q_ncs_high", 0, last_hi[0], 3);
      chk("q_frame2", 0, dec[0], 16'h8234);
      chk("q_rdata2", 0, rdata[0], 8'h0F);

      // Reset while bit 7 is in its high phase.
      send(0, 1'b1, 7'h2A, 8'h5B, 16'hFFFF);
      for (int k = 0; k < 100 && m_t[0] < 33; k++) step();
      chk("pre_rst_sclk", 0, sclk[0], 1'b1);
      d0 = donec[0];
      rst = 1'b1;
      #1;
      chk("rst_ncs", 0, ncs[0], 1'b1);
      chk("rst_sclk", 0, sclk[0], 1'b0);
      chk("rst_busy", 0, busy[0], 1'b0);
      chk("rst_rdata", 0, rdata[0], 8'h00);
      repeat (3) step();
      chk("rst_no_done", 0, donec[0] - d0, 0);
      rst = 1'b0;
      d0 = donec[0];
      send(0, 1'b0, 7'h11, 8'h77, 16'h003E);
      chk("rst_first_accept", 0, acc_cyc[0], cyc);
      wait_idle(0);
      chk("rst_next_frame", 0, dec[0], 16'h1177);
      chk("rst_next_rdata", 0, rdata[0], 8'h3E);
      chk("rst_next_done", 0, donec[0] - d0, 1);

      // Minimum timing instance.
      r0 = rises[1]; l0 = lowc[1];
      send(1, 1'b1, 7'h43, 8'hAA, 16'h5A5A);
      wait_idle(1);
      chk("min_frame", 1, dec[1], 16'hC3AA);
      chk("min_ncs_low", 1, lowc[1] - l0, 34);
      chk("min_rises", 1, rises[1] - r0, 16);
      chk("min_rise_period", 1, rise_gap[1], 2);

      // Random traffic on both instances, with occasional resets.
      rst_cnt = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int g = 0; g < 2; g++) begin
            req_valid[g] = ($urandom_range(0, 3) != 0);
            req_write[g] = 1'($urandom);
            req_addr[g]  = 7'($urandom);
            req_wdata[g] = 8'($urandom);
            cw_next[g]   = 16'($urandom);
         end
         if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) rst = 1'b0;
         end else if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1;
            rst_cnt = 2;
         end
         step();
      end
      rst = 1'b0;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      wait_idle(0);
      wait_idle(1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
